// File: rtl/csa_calc_multi_wrap.sv
// csa_calc_multi_wrap: buffers CSA parameter records, dispatches them round-robin to
// external calculation lanes and returns {result, record} in issue or completion order.
module csa_calc_multi_wrap #(
    parameter int AXI_DATA_WIDTH     = 32,
    parameter int CSA_CALC_IN_WIDTH  = 64,
    parameter int CSA_CALC_OUT_WIDTH = 64,
    parameter int NUM_LANES          = 4,
    parameter int IN_DEPTH           = 16,
    parameter int OUT_DEPTH          = 16,
    parameter int IN_LEN             = AXI_DATA_WIDTH * 5,
    parameter int OUT_LEN            = IN_LEN + CSA_CALC_OUT_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    order_mode,
    input  logic                                    csa_in_wen,
    input  logic [IN_LEN-1:0]                       csa_in,
    output logic                                    csa_in_full,
    input  logic                                    csa_out_ren,
    output logic [OUT_LEN-1:0]                      csa_out,
    output logic                                    csa_out_ready,
    output logic [NUM_LANES-1:0]                    lane_start,
    output logic [IN_LEN-1:0]                       lane_param,
    input  logic [NUM_LANES-1:0]                    lane_done,
    input  logic [NUM_LANES*CSA_CALC_OUT_WIDTH-1:0] lane_out,
    output logic [31:0]                             drop_count,
    output logic [31:0]                             done_count
);
    localparam int LW  = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int SW  = OAW + 1;

    if (CSA_CALC_IN_WIDTH > 2 * AXI_DATA_WIDTH) begin : g_bad_width
        $error("CSA_CALC_IN_WIDTH exceeds 2*AXI_DATA_WIDTH");
    end

    typedef enum logic [1:0] {FREE, RUN, HELD} lane_st_t;

    logic [IN_LEN-1:0]             in_mem [IN_DEPTH];
    logic [IAW-1:0]                in_wp, in_rp;
    logic [IAW:0]                  in_cnt;
    logic [OUT_LEN-1:0]            out_mem [OUT_DEPTH];
    logic [OAW-1:0]                out_wp, out_rp;
    logic [OAW:0]                  out_cnt;
    lane_st_t                      st [NUM_LANES];
    logic [IN_LEN-1:0]             rec [NUM_LANES];
    logic [CSA_CALC_OUT_WIDTH-1:0] res [NUM_LANES];
    logic [SW-1:0]                 tag [NUM_LANES];
    logic [SW-1:0]                 seq_issue, seq_next;
    logic [LW-1:0]                 rr_ptr, grant, gnt_hi, gnt_lo, dsel;
    logic [NUM_LANES-1:0]          cap;
    logic                          mode_q, any_free, all_free, hi_found, disp, drain, wr, pop;
    int                            busy;

    assign csa_in_full   = in_cnt == (IAW+1)'(IN_DEPTH);
    assign csa_out_ready = |out_cnt;
    assign csa_out       = csa_out_ready ? out_mem[out_rp] : '0;
    assign wr            = csa_in_wen && !csa_in_full;
    assign pop           = csa_out_ren && csa_out_ready;

    // Descending scans leave the lowest qualifying index in gnt_lo/gnt_hi/dsel.
    always_comb begin
        busy     = 0;
        any_free = 1'b0;
        all_free = 1'b1;
        hi_found = 1'b0;
        gnt_hi   = '0;
        gnt_lo   = '0;
        drain    = 1'b0;
        dsel     = '0;
        cap      = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            cap[i] = st[i] == RUN && lane_done[i];
            busy   = busy + ((st[i] != FREE) ? 1 : 0);
            if (st[i] == FREE) begin
                any_free = 1'b1;
                gnt_lo   = LW'(i);
                if (i > int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    gnt_hi   = LW'(i);
                end
            end else all_free = 1'b0;
            if (st[i] == HELD && (mode_q || tag[i] == seq_next)) begin
                drain = 1'b1;
                dsel  = LW'(i);
            end
        end
        grant = hi_found ? gnt_hi : gnt_lo;
        // Credit rule: every in-flight record already owns an output FIFO slot.
        disp  = |in_cnt && any_free && int'(out_cnt) + busy < OUT_DEPTH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_wp      <= '0;
            in_rp      <= '0;
            in_cnt     <= '0;
            out_wp     <= '0;
            out_rp     <= '0;
            out_cnt    <= '0;
            rr_ptr     <= LW'(NUM_LANES - 1);
            seq_issue  <= '0;
            seq_next   <= '0;
            mode_q     <= order_mode;
            lane_start <= '0;
            lane_param <= '0;
            drop_count <= '0;
            done_count <= '0;
            for (int i = 0; i < NUM_LANES; i++) st[i] <= FREE;
        end else begin
            in_wp      <= in_wp + IAW'(wr);
            in_rp      <= in_rp + IAW'(disp);
            in_cnt     <= in_cnt + (IAW+1)'(wr) - (IAW+1)'(disp);
            out_wp     <= out_wp + OAW'(drain);
            out_rp     <= out_rp + OAW'(pop);
            out_cnt    <= out_cnt + (OAW+1)'(drain) - (OAW+1)'(pop);
            lane_start <= disp ? NUM_LANES'(1) << grant : '0;
            if (csa_in_wen && csa_in_full && ~&drop_count) drop_count <= drop_count + 32'd1;
            if (disp) begin
                lane_param <= in_mem[in_rp];
                rr_ptr     <= grant;
                seq_issue  <= seq_issue + SW'(1);
            end
            if (drain) begin
                seq_next   <= seq_next + SW'(1);
                done_count <= done_count + 32'd1;
            end
            if (all_free) mode_q <= order_mode;
            for (int i = 0; i < NUM_LANES; i++)
                st[i] <= (disp && grant == LW'(i)) ? RUN :
                         cap[i] ? HELD :
                         (drain && dsel == LW'(i)) ? FREE : st[i];
        end
    end

    always_ff @(posedge clk) begin
        if (wr) in_mem[in_wp] <= csa_in;
        if (drain) out_mem[out_wp] <= {res[dsel], rec[dsel]};
        for (int i = 0; i < NUM_LANES; i++) begin
            if (disp && grant == LW'(i)) begin
                rec[i] <= in_mem[in_rp];
                tag[i] <= seq_issue;
            end
            if (cap[i]) res[i] <= lane_out[i*CSA_CALC_OUT_WIDTH +: CSA_CALC_OUT_WIDTH];
        end
    end
endmodule

// File: tb/tb_csa_calc_multi_wrap.sv
// tb_csa_calc_multi_wrap: directed table and sequence checks of csa_calc_multi_wrap
// with four lanes driven by hand and a four-entry output FIFO.
module tb_csa_calc_multi_wrap;
    localparam int NL = 4, ID = 16, OD = 4, IL = 160, RW = 64, OL = IL + RW;

    logic            clk = 1'b0, rst, order_mode, csa_in_wen, csa_out_ren;
    logic [IL-1:0]   csa_in, lane_param;
    logic            csa_in_full, csa_out_ready;
    logic [OL-1:0]   csa_out;
    logic [NL-1:0]   lane_start, lane_done;
    logic [NL*RW-1:0] lane_out;
    logic [31:0]     drop_count, done_count;
    int              checks = 0, failures = 0;

    typedef struct {
        logic [IL-1:0] rec;
        logic [NL-1:0] start;
        int            lane;
    } vec_t;

    always #5 clk = ~clk;

    csa_calc_multi_wrap #(.NUM_LANES(NL), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
        .clk(clk), .rst(rst), .order_mode(order_mode),
        .csa_in_wen(csa_in_wen), .csa_in(csa_in), .csa_in_full(csa_in_full),
        .csa_out_ren(csa_out_ren), .csa_out(csa_out), .csa_out_ready(csa_out_ready),
        .lane_start(lane_start), .lane_param(lane_param),
        .lane_done(lane_done), .lane_out(lane_out),
        .drop_count(drop_count), .done_count(done_count)
    );

    function automatic logic [IL-1:0] mkrec(input int k);
        logic [31:0] kk;
        kk = k;
        return {32'hDEAD0000 | kk, 32'h00010000 + kk, ~kk, 32'h5A5A0000 ^ kk, 32'h000000FF + kk};
    endfunction

    function automatic logic [RW-1:0] res_of(input int l);
        return 64'hCAFEF00D_00000000 | 64'(l);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic m);
        rst = 1'b1; order_mode = m; csa_in_wen = 1'b0; csa_out_ren = 1'b0; lane_done = '0;
        tick;
        rst = 1'b0;
    endtask

    task automatic wr(input logic [IL-1:0] r);
        csa_in_wen = 1'b1;
        csa_in = r;
        tick;
        csa_in_wen = 1'b0;
    endtask

    task automatic pop_chk(input string nm, input logic [OL-1:0] exp);
        chk(nm, {csa_out_ready, csa_out}, {1'b1, exp});
        csa_out_ren = 1'b1;
        tick;
        csa_out_ren = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_full"}, csa_in_full, 0);
        chk({nm, "_ready"}, csa_out_ready, 0);
        chk({nm, "_out"}, csa_out, 0);
        chk({nm, "_start"}, lane_start, 0);
        chk({nm, "_param"}, lane_param, 0);
        chk({nm, "_drop"}, drop_count, 0);
        chk({nm, "_done"}, done_count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t          tv [5];
        logic [IL-1:0] sb [$];
        int            got, starts;
        tv[0] = '{mkrec(1), 4'b0001, 0};
        tv[1] = '{mkrec(2), 4'b0010, 1};
        tv[2] = '{mkrec(3), 4'b0100, 2};
        tv[3] = '{mkrec(4), 4'b1000, 3};
        tv[4] = '{mkrec(5), 4'b0001, 0};
        for (int l = 0; l < NL; l++) lane_out[l*RW +: RW] = res_of(l);
        csa_in = '0;
        do_reset(1'b0);
        tick;
        chk_zero_outputs("reset");

        // Single records through each lane in turn: round-robin grant and 2-edge drain latency.
        for (int k = 0; k < 5; k++) begin
            wr(tv[k].rec);
            tick;
            chk($sformatf("tv%0d_start", k), lane_start, tv[k].start);
            chk($sformatf("tv%0d_param", k), lane_param, tv[k].rec);
            lane_done = tv[k].start;
            tick;
            lane_done = '0;
            chk($sformatf("tv%0d_not_ready", k), csa_out_ready, 0);
            tick;
            chk($sformatf("tv%0d_done_count", k), done_count, k + 1);
            pop_chk($sformatf("tv%0d_out", k), {res_of(tv[k].lane), tv[k].rec});
            chk($sformatf("tv%0d_empty", k), csa_out_ready, 0);
        end

        // Issue order: done pulses 2,0,1 must still emerge 0,1,2.
        do_reset(1'b0);
        wr(mkrec(10)); wr(mkrec(11)); wr(mkrec(12));
        tick;
        chk("io_start2", lane_start, 4'b0100);
        lane_done = 4'b0100; tick;
        chk("io_lane2_held", csa_out_ready, 0);
        lane_done = 4'b0001; tick;
        chk("io_lane0_pending", csa_out_ready, 0);
        lane_done = 4'b0010; tick;
        lane_done = '0;
        chk("io_dc1", done_count, 1);
        tick;
        chk("io_dc2", done_count, 2);
        tick;
        chk("io_dc3", done_count, 3);
        pop_chk("io_out0", {res_of(0), mkrec(10)});
        pop_chk("io_out1", {res_of(1), mkrec(11)});
        pop_chk("io_out2", {res_of(2), mkrec(12)});

        // Completion order: lane 2 first, then simultaneous 0 and 1 drain lowest first.
        do_reset(1'b1);
        wr(mkrec(20)); wr(mkrec(21)); wr(mkrec(22));
        tick;
        lane_done = 4'b0100; tick;
        chk("co_not_ready", csa_out_ready, 0);
        lane_done = 4'b0011; tick;
        lane_done = '0;
        chk("co_dc1", done_count, 1);
        tick;
        chk("co_dc2", done_count, 2);
        tick;
        chk("co_dc3", done_count, 3);
        pop_chk("co_out0", {res_of(2), mkrec(22)});
        pop_chk("co_out1", {res_of(0), mkrec(20)});
        pop_chk("co_out2", {res_of(1), mkrec(21)});

        // Full and drop: all lanes busy, 18 writes into a 16-entry FIFO.
        do_reset(1'b0);
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            wr(mkrec(100 + i));
            sb.push_back(mkrec(100 + i));
        end
        tick; tick;
        for (int i = 1; i <= 18; i++) begin
            wr(mkrec(200 + i));
            if (i <= 16) sb.push_back(mkrec(200 + i));
            if (i == 15) chk("fd_full_15", csa_in_full, 0);
            if (i == 16) begin
                chk("fd_full_16", csa_in_full, 1);
                chk("fd_drop_16", drop_count, 0);
            end
        end
        chk("fd_full_18", csa_in_full, 1);
        chk("fd_drop_18", drop_count, 2);
        got = 0;
        lane_done = '1;
        for (int c = 0; c < 400 && got < 20; c++) begin
            if (csa_out_ready) begin
                chk($sformatf("fd_rec%0d", got), csa_out[IL-1:0], sb[got]);
                got++;
                csa_out_ren = 1'b1;
            end else csa_out_ren = 1'b0;
            tick;
        end
        csa_out_ren = 1'b0;
        lane_done = '0;
        chk("fd_all_drained", got, 20);
        chk("fd_full_cleared", csa_in_full, 0);
        chk("fd_drop_kept", drop_count, 2);

        // Reset with three lanes running discards everything; stale done pulses are ignored.
        wr(mkrec(30)); wr(mkrec(31)); wr(mkrec(32));
        tick;
        rst = 1'b1; tick; rst = 1'b0;
        chk_zero_outputs("midrst");
        lane_done = 4'b0111; tick;
        lane_done = '0;
        tick; tick; tick;
        chk("midrst_no_out", csa_out_ready, 0);
        chk("midrst_no_done", done_count, 0);
        wr(mkrec(33));
        tick;
        chk("midrst_lane0", lane_start, 4'b0001);

        // Credit backpressure: four-slot output FIFO caps starts at four until a pop.
        do_reset(1'b0);
        lane_done = '1;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            wr(mkrec(300 + i));
            starts += $countones(lane_start);
        end
        for (int c = 0; c < 30; c++) begin
            tick;
            starts += $countones(lane_start);
        end
        chk("cr_starts", starts, 4);
        chk("cr_done_count", done_count, 4);
        chk("cr_ready", csa_out_ready, 1);
        csa_out_ren = 1'b1; tick; csa_out_ren = 1'b0;
        starts = $countones(lane_start);
        for (int c = 0; c < 20; c++) begin
            tick;
            starts += $countones(lane_start);
        end
        chk("cr_one_more", starts, 1);
        lane_done = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
